instr_align_queue: RTL
======================

Name: instr_align_queue

Overview:
- Fetch-side parcel queue that sits between the instruction fetch unit and the decoders (decoder16 / 32-bit decoder).
- Accepts fetch packets of FETCH_PARCELS 16-bit parcels and buffers them in a circular parcel queue.
- Each cycle it extracts up to ISSUE_W length-resolved instructions (16- or 32-bit) with per-instruction pc and is_rvc flag.
- Handles 32-bit instructions that straddle fetch packets and a mid-packet entry point after redirect.

Parameters:
- FETCH_PARCELS, 4, 16-bit parcels per fetch packet (power of 2; 4 gives a 64-bit fetch).
- DEPTH, 16, queue capacity in parcels (power of 2, >= 2*FETCH_PARCELS).
- ISSUE_W, 2, maximum instructions presented per cycle (1 or 2).

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active-high.
- flush  in  1  pipeline redirect; empties the queue.
- fetch_valid  in  1  fetch packet present.
- fetch_ready  out  1  queue can accept a whole packet.
- fetch_data  in  16*FETCH_PARCELS  packet; parcel i is at [16i+15:16i].
- fetch_pc  in  64  pc of parcel 0.
- fetch_offset  in  $clog2(FETCH_PARCELS)  first valid parcel index.
- instr_valid  out  ISSUE_W  per-lane valid; set lanes are contiguous from lane 0.
- instr_ready  in  1  consumer takes all valid lanes.
- instr_data  out  32*ISSUE_W  instructions; RVC instructions are zero-extended in [15:0].
- instr_pc  out  64*ISSUE_W  per-lane pc.
- instr_is_rvc  out  ISSUE_W  per-lane 16-bit flag.

Behaviour:
- Reset and interface:
  - Clock is CLK; reset is RST, synchronous and active-high.
  - Reset values: head ptr 0, tail ptr 0, count 0, head_pc 0, need_pc 1, instr_valid 0, fetch_ready 1.
- State:
  - Parcel array DEPTH x 16.
  - head/tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is $clog2(DEPTH)+1 bits.
  - head_pc is 64 bits.
  - need_pc flag.
- Push:
  - fetch_ready = (DEPTH - count >= FETCH_PARCELS), computed from the registered count only; it does not credit a same-cycle pop.
  - A push occurs when fetch_valid & fetch_ready.
  - If need_pc=1: write parcels fetch_offset..FETCH_PARCELS-1 at tail; count += FETCH_PARCELS-fetch_offset; head_pc <= fetch_pc + 2*fetch_offset; need_pc <= 0.
  - If need_pc=0: fetch_offset and fetch_pc are ignored; all parcels are written, since packets are sequential.
- Length rule:
  - Parcel[1:0]==2'b11 means 32-bit (2 parcels); otherwise 16-bit (1 parcel).
- Extraction (combinational from registered state):
  - lane0 starts at head. It is valid if count>=1 and the instruction is 16-bit, or count>=2 and it is 32-bit.
  - lane k starts immediately after lane k-1. It is valid only if lane k-1 is valid and enough parcels remain.
  - A 32-bit instruction is {parcel[p+1], parcel[p]}.
  - lane pc = head_pc + 2*(parcels preceding the lane).
  - A lone low half of a 32-bit instruction at the tail yields no valid lane; it waits for the next push.
- Pop:
  - Occurs when instr_ready & instr_valid[0].
  - Consumes all valid lanes: head += total parcels, count -= total, head_pc += 2*total.
- Simultaneous push and pop:
  - count_next = count + pushed - popped.
  - Array write and read never conflict, because push requires free space.
- Latency: a packet pushed in cycle N is visible on the instr outputs in cycle N+1.
- Flush:
  - Same register effect as reset, except head_pc is held.
  - Has priority over a same-cycle push (packet dropped) and pop (no effect).
  - instr_valid is 0 the cycle after flush.
- Assertions: count never exceeds DEPTH, and count never underflows.

Optional Feature:
- Macro: RIFT_RVC_EN.
- Defined:
  - Mixed 16/32-bit extraction as described.
  - fetch_offset may be odd.
- Undefined:
  - Every instruction is 2 parcels and instr_is_rvc is always 0.
  - Parcel[1:0] is not examined.
  - fetch_offset[0] is ignored (treated as 0), so head_pc stays 4-aligned.
  - No 16-bit length logic is synthesised.

Test Plan:
- Reset, then push 4x 0x0001 at pc 0x8000_0000 with offset 0, instr_ready=1.
  - Next cycle: valid=11, pcs 0x8000_0000/0x8000_0002, is_rvc=11.
  - Following cycle: pcs 0x8000_0004/0x8000_0006.
  - Then valid=00.
- Straddle: push parcels {0x4501, 0x0513, 0x0000, 0x0093} at pc X.
  - Lane0 0x00004501 (rvc) at X; lane1 0x00000513 at X+2.
  - Then valid=00 with count=1.
  - Push next packet with parcel0=0x0010: lane0 0x00100093 at X+6, is_rvc=0.
- Full: instr_ready=0, push 32-bit-only packets.
  - fetch_ready drops after the 4th push (count=16); 5th packet held.
  - One pop of 2x32-bit instructions (4 parcels) restores fetch_ready the next cycle.
- Flush with simultaneous fetch_valid.
  - Next cycle count=0, valid=00, packet not stored.
  - Next push at pc 0x8000_1000 with offset=2: lane0 pc 0x8000_1004 from parcel 2.
- Wrap: 10 packets of mixed RVC/32-bit with continuous pop, including a 32-bit instruction spanning index 15 to index 0.
  - pc sequence and data must match a reference model.
  - No lost or duplicated parcels.
- RIFT_RVC_EN undefined: parcels {0x4501, 0x0000} yield one lane 0x00004501 with is_rvc=0.

Source files
------------

// File: rtl/instr_align_queue.sv
// instr_align_queue
//   Fetch-side parcel queue between the fetch unit and the decoders. Fetch packets of
//   FETCH_PARCELS 16-bit parcels are buffered in a circular parcel array; each cycle up to
//   ISSUE_W length-resolved instructions are presented with their pc and an RVC flag.
//   32-bit instructions may straddle packets, and the first packet after a redirect may
//   enter mid-packet (fetch_offset).
//
// Configuration macro:
//   RIFT_RVC_EN  defined:   mixed 16/32-bit extraction, odd fetch_offset allowed.
//                undefined: every instruction is two parcels, instr_is_rvc is 0 and
//                           fetch_offset[0] is ignored.
//
// Ports:
//   CLK, RST       clock, synchronous active-high reset
//   flush          redirect; empties the queue (head pc held)
//   fetch_valid    packet present        fetch_ready  room for a whole packet
//   fetch_data     packet, parcel i at [16i+15:16i]
//   fetch_pc       pc of parcel 0        fetch_offset first valid parcel (after redirect)
//   instr_valid    per-lane valid, contiguous from lane 0
//   instr_ready    consumer takes all valid lanes
//   instr_data     per-lane instruction, RVC zero-extended in [15:0]
//   instr_pc       per-lane pc           instr_is_rvc per-lane 16-bit flag
module instr_align_queue #(
  parameter int unsigned FETCH_PARCELS = 4,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned ISSUE_W       = 2,
  localparam int unsigned OffW = (FETCH_PARCELS > 1) ? $clog2(FETCH_PARCELS) : 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       flush,
  input  logic                       fetch_valid,
  output logic                       fetch_ready,
  input  logic [16*FETCH_PARCELS-1:0] fetch_data,
  input  logic [63:0]                fetch_pc,
  input  logic [OffW-1:0]            fetch_offset,
  output logic [ISSUE_W-1:0]         instr_valid,
  input  logic                       instr_ready,
  output logic [32*ISSUE_W-1:0]      instr_data,
  output logic [64*ISSUE_W-1:0]      instr_pc,
  output logic [ISSUE_W-1:0]         instr_is_rvc
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [15:0]     r_mem [DEPTH];
  logic [PtrW-1:0] r_head;
  logic [PtrW-1:0] r_tail;
  logic [CntW-1:0] r_count;
  logic [63:0]     r_head_pc;
  logic            r_need_pc;

  logic            w_push;
  logic            w_pop;
  logic [OffW-1:0] w_eff_off;
  logic [CntW-1:0] w_push_n;
  logic [CntW-1:0] w_pop_n;

  // Ready looks only at the registered count; a same-cycle pop is not credited.
  assign fetch_ready = (r_count <= CntW'(DEPTH - FETCH_PARCELS));
  assign w_push      = fetch_valid & fetch_ready;
  assign w_pop       = instr_ready & instr_valid[0];

  // The entry offset only applies to the first packet after reset/flush.
  always_comb begin
    w_eff_off = r_need_pc ? fetch_offset : '0;
`ifndef RIFT_RVC_EN
    w_eff_off[0] = 1'b0;
`endif
    w_push_n = CntW'(FETCH_PARCELS) - CntW'(w_eff_off);
  end

  // Lane extraction: walk the queue from head, each lane starting where the previous ended.
  always_comb begin
    logic [CntW-1:0] off;
    logic [CntW-1:0] len;
    logic [PtrW-1:0] idx0;
    logic [PtrW-1:0] idx1;
    logic [15:0]     p0;
    logic [15:0]     p1;
    logic            is32;
    logic            prev;
    off          = '0;
    len          = '0;
    idx0         = '0;
    idx1         = '0;
    p0           = '0;
    p1           = '0;
    is32         = 1'b0;
    prev         = 1'b1;
    instr_valid  = '0;
    instr_data   = '0;
    instr_pc     = '0;
    instr_is_rvc = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      idx0 = r_head + off[PtrW-1:0];
      idx1 = idx0 + PtrW'(1);
      p0   = r_mem[idx0];
      p1   = r_mem[idx1];
`ifdef RIFT_RVC_EN
      is32 = (p0[1:0] == 2'b11);
`else
      is32 = 1'b1;
`endif
      len = is32 ? CntW'(2) : CntW'(1);
      // A lone low half at the tail is not valid; it waits for the next packet.
      instr_valid[k]        = prev && (r_count >= off + len);
      instr_data[32*k +: 32] = is32 ? {p1, p0} : {16'h0000, p0};
      instr_pc[64*k +: 64]   = r_head_pc + (64'(off) << 1);
      instr_is_rvc[k]       = ~is32;
      if (instr_valid[k]) begin
        off = off + len;
      end
      prev = instr_valid[k];
    end
    w_pop_n = off;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_head_pc <= '0;
      r_need_pc <= 1'b1;
    end else if (flush) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_need_pc <= 1'b1;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + w_push_n[PtrW-1:0];
      end
      if (w_pop) begin
        r_head <= r_head + w_pop_n[PtrW-1:0];
      end
      r_count <= r_count + (w_push ? w_push_n : '0) - (w_pop ? w_pop_n : '0);
      // need_pc implies an empty queue, so a pop cannot coincide with the pc load.
      if (w_push && r_need_pc) begin
        r_head_pc <= fetch_pc + (64'(w_eff_off) << 1);
        r_need_pc <= 1'b0;
      end else if (w_pop) begin
        r_head_pc <= r_head_pc + (64'(w_pop_n) << 1);
      end
    end
  end

  // Parcel array: packed write from tail, skipping parcels below the entry offset.
  always_ff @(posedge CLK) begin
    if (!RST && !flush && w_push) begin
      for (int i = 0; i < FETCH_PARCELS; i++) begin
        if (32'(i) >= 32'(w_eff_off)) begin
          r_mem[r_tail + PtrW'(i) - PtrW'(w_eff_off)] <= fetch_data[16*i +: 16];
        end
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge CLK) begin
    if (!RST) begin
      assert (r_count <= CntW'(DEPTH));
      assert (!w_pop || (w_pop_n <= r_count));
    end
  end
`endif

endmodule
